simple_dp_ram: RTL and testbench
================================

Name: simple_dp_ram

Overview:
Simple dual-port synchronous RAM with one write port and one read port on a single clock. The write port has per-byte enables. Used as the core's data/instruction storage in the RISC-V SoC. Addresses are word indices, not byte addresses.

Parameters:
DW, 32, data width in bits; must be a multiple of 8.
AW, 32, address width in bits for both ports.
MEM_NUM, 4096, number of DW-bit words; need not be a power of two.

Ports:
clk  input  1  clock; all storage and r_data update on the rising edge.
rstn  input  1  asynchronous active-low reset.
wen  input  DW/8  byte write enables; bit k covers w_data[8k+7:8k].
w_addr  input  AW  write word index.
w_data  input  DW  write data.
ren  input  1  read enable.
r_addr  input  AW  read word index.
r_data  output  DW  registered read data.

Behaviour:
- Reset: rstn low immediately clears r_data to 0, with no clock required. Memory array contents are not reset and are preserved across reset. Writes and reads are ignored while rstn is low.
- Write: on a rising edge with rstn high and w_addr < MEM_NUM, byte lane k of mem[w_addr] is updated with w_data lane k for every k where wen[k]=1. Lanes with wen[k]=0 are unchanged. wen=0 means no write.
- Write out of range: if w_addr >= MEM_NUM, the write is dropped silently. There is no wrap-around and no aliasing; compare the full AW-bit address.
- Read: on a rising edge with ren=1 and rstn high, r_data <= mem[r_addr]. Data is visible one cycle after the request, so latency is 1.
- Read out of range: ren=1 with r_addr >= MEM_NUM loads r_data <= 0.
- ren=0: r_data holds its previous value.
- Uninitialised words read as X in simulation. No init file is loaded.
- Same-cycle read and write to the same in-range address: governed by the optional feature below. The default is read-first, returning the old contents.
- Simultaneous read and write to different addresses are fully independent.
- Back-to-back: one write and one read can be accepted every cycle with no stalls. No handshake; both ports are always ready.

Optional Feature:
Macro RAM_WR_BYPASS_EN.
- Defined: write-first. When ren=1, wen!=0, rstn high, r_addr==w_addr and the address is < MEM_NUM, r_data takes w_data in enabled lanes and the old mem contents in disabled lanes, in that same edge.
- Not defined: read-first. r_data gets the pre-write contents of all lanes. The memory is still updated by the write.

Test Plan:
- Reset check: hold rstn=0 for 1 cycle. Expect r_data=0 during reset and after release.
- Fill and readback: for i=0..15, write w_addr=i, w_data=i+1, wen=4'b1111, one per cycle. Then for i=0..15 read r_addr=i with ren=1. Expect r_data=i+1 one cycle after each read request.
- Byte lanes: write 0xAABBCCDD to addr 5 with wen=1111. Then write 0x11223344 with wen=0101. Read addr 5 and expect 0xAA22CC44.
- Hold and out-of-range: with r_data showing the addr 5 value, set ren=0 for 3 cycles and expect r_data unchanged. Write 0xDEADBEEF to addr 4096 (MEM_NUM), then read addr 4096 and expect 0. Read addr 0 and expect it unchanged at 1.
- Collision: mem[7]=0x12345678. In one cycle write 0xFFFFFFFF with wen=1111 to addr 7 and read addr 7. Expect r_data=0x12345678 without RAM_WR_BYPASS_EN, or 0xFFFFFFFF with it. The next read of addr 7 returns 0xFFFFFFFF in both builds.
- Reset mid-stream: assert rstn=0 asynchronously between edges during a read sequence. Expect r_data=0 immediately. After release, reading addr 3 returns 4, showing contents are preserved.

Source files
------------

// File: rtl/simple_dp_ram.sv
// Simple dual-port synchronous RAM: one byte-enabled write port, one registered read port.
// Optional macro RAM_WR_BYPASS_EN selects write-first collision behaviour (default read-first).
module simple_dp_ram #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_NUM = 4096
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [DW/8-1:0] wen,
    input  logic [AW-1:0]   w_addr,
    input  logic [DW-1:0]   w_data,
    input  logic            ren,
    input  logic [AW-1:0]   r_addr,
    output logic [DW-1:0]   r_data
);

    localparam int NB = DW / 8;
    localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    // Full-width limit so out-of-range addresses never alias onto a truncated index.
    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_NUM);

    logic [DW-1:0] mem [0:MEM_NUM-1];

    logic          w_in_range_s;
    logic          r_in_range_s;
    logic [IW-1:0] w_idx_s;
    logic [IW-1:0] r_idx_s;
    logic [DW-1:0] r_data_d;
    logic [DW-1:0] r_data_q;

    function automatic logic [DW-1:0] merge_lanes(
        input logic [DW-1:0] old_word,
        input logic [DW-1:0] new_word,
        input logic [NB-1:0] lane_en
    );
        logic [DW-1:0] res;
        res = {DW{1'b0}};
        for (int k = 0; k < NB; k++) begin
            if (lane_en[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign w_in_range_s = ({1'b0, w_addr} < MEM_LIMIT);
    assign r_in_range_s = ({1'b0, r_addr} < MEM_LIMIT);
    assign w_idx_s      = w_addr[IW-1:0];
    assign r_idx_s      = r_addr[IW-1:0];

    // Storage update: per-lane writes, never reset, suppressed while rstn is low.
    always_ff @(posedge clk) begin
        if (rstn && w_in_range_s) begin
            for (int k = 0; k < NB; k++) begin
                if (wen[k]) begin
                    mem[w_idx_s][8*k +: 8] <= w_data[8*k +: 8];
                end
            end
        end
    end

    // Next read data: hold, zero for out-of-range, or array word (merged on collision when bypassing).
    always_comb begin
        r_data_d = r_data_q;
        if (ren) begin
            if (r_in_range_s) begin
`ifdef RAM_WR_BYPASS_EN
                if (w_in_range_s && (r_addr == w_addr)) begin
                    r_data_d = merge_lanes(mem[r_idx_s], w_data, wen);
                end else begin
                    r_data_d = mem[r_idx_s];
                end
`else
                r_data_d = mem[r_idx_s];
`endif
            end else begin
                r_data_d = {DW{1'b0}};
            end
        end else begin
            r_data_d = r_data_q;
        end
    end

    // Read data register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_q <= {DW{1'b0}};
        end else begin
            r_data_q <= r_data_d;
        end
    end

    assign r_data = r_data_q;

endmodule

// File: tb/tb_simple_dp_ram.sv
// Directed table-driven bench for simple_dp_ram, plus hand-written reset sequences.
module tb_simple_dp_ram;

    logic        clk;
    logic        rstn;
    logic [3:0]  wen;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        ren;
    logic [31:0] r_addr;
    logic [31:0] r_data;

    int checks;
    int errors;

`ifdef RAM_WR_BYPASS_EN
    localparam logic [31:0] COLL_FULL = 32'hFFFF_FFFF;
    localparam logic [31:0] COLL_PART = 32'h0000_C3D4;
`else
    localparam logic [31:0] COLL_FULL = 32'h1234_5678;
    localparam logic [31:0] COLL_PART = 32'h0000_000B;
`endif

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] w_addr;
        logic [31:0] w_data;
        logic        ren;
        logic [31:0] r_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    simple_dp_ram dut (
        .clk    (clk),
        .rstn   (rstn),
        .wen    (wen),
        .w_addr (w_addr),
        .w_data (w_data),
        .ren    (ren),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] a_wen, input logic [31:0] a_waddr,
                                input logic [31:0] a_wdata, input logic a_ren,
                                input logic [31:0] a_raddr, input logic [31:0] a_exp);
        vec_t v;
        v.wen = a_wen; v.w_addr = a_waddr; v.w_data = a_wdata;
        v.ren = a_ren; v.r_addr = a_raddr; v.exp = a_exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (r_data !== exp) begin
            errors++;
            $display("FAIL %s: r_data got %h expected %h", name, r_data, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a_wen, input logic [31:0] a_waddr,
                         input logic [31:0] a_wdata, input logic a_ren, input logic [31:0] a_raddr);
        wen = a_wen; w_addr = a_waddr; w_data = a_wdata; ren = a_ren; r_addr = a_raddr;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b1;
        drive(4'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Fill 0..15 with i+1, then read each back.
        for (int i = 0; i < 16; i++) add(4'hF, 32'(i), 32'(i + 1), 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) add(4'h0, 32'h0, 32'h0, 1'b1, 32'(i), 32'(i + 1));
        // Byte lanes.
        add(4'hF, 32'd5, 32'hAABB_CCDD, 1'b0, 32'h0, 32'd16);
        add(4'h5, 32'd5, 32'h1122_3344, 1'b0, 32'h0, 32'd16);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd5, 32'hAA22_CC44);
        // Hold with ren=0.
        for (int i = 0; i < 3; i++) add(4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hAA22_CC44);
        // Out-of-range write and reads; addr 0 must not be aliased by 4096.
        add(4'hF, 32'd4096, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hAA22_CC44);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd4096, 32'h0);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd0, 32'd1);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        // wen=0 is no write, even on a same-address read.
        add(4'h0, 32'd2, 32'h0000_0BAD, 1'b1, 32'd2, 32'd3);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd2, 32'd3);
        // Independent ports on different addresses.
        add(4'hF, 32'd8, 32'h0000_0055, 1'b1, 32'd9, 32'd10);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd8, 32'h0000_0055);
        // Collisions: full-word and partial-lane.
        add(4'hF, 32'd7, 32'h1234_5678, 1'b0, 32'h0, 32'h0000_0055);
        add(4'hF, 32'd7, 32'hFFFF_FFFF, 1'b1, 32'd7, COLL_FULL);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd7, 32'hFFFF_FFFF);
        add(4'h3, 32'd10, 32'hA1B2_C3D4, 1'b1, 32'd10, COLL_PART);
        add(4'h0, 32'h0, 32'h0, 1'b1, 32'd10, 32'h0000_C3D4);

        // Reset: asserted between edges, checked before any clock, held one cycle.
        #2 rstn = 1'b0;
        #1 check("reset_async", 32'h0);
        @(posedge clk); #1;
        check("reset_held", 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("reset_release", 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wen, vecs[i].w_addr, vecs[i].w_data, vecs[i].ren, vecs[i].r_addr);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset mid-stream during reads; write while in reset must be ignored.
        drive(4'h0, 32'h0, 32'h0, 1'b1, 32'd1);
        @(posedge clk); #1;
        check("mid_read1", 32'd2);
        #2 rstn = 1'b0;
        #1 check("mid_async_clear", 32'h0);
        drive(4'hF, 32'd3, 32'h0000_0099, 1'b1, 32'd2);
        @(posedge clk); #1;
        check("mid_rst_ignore_read", 32'h0);
        rstn = 1'b1;
        drive(4'h0, 32'h0, 32'h0, 1'b1, 32'd3);
        @(posedge clk); #1;
        check("mid_preserve3", 32'd4);
        drive(4'h0, 32'h0, 32'h0, 1'b1, 32'd2);
        @(posedge clk); #1;
        check("mid_preserve2", 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
